// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg
//   ID/EX pipeline register for a 5-stage MIPS pipeline with built-in
//   load-use hazard detection. It inserts bubbles and handles branch
//   flush and whole-pipe freeze. It also keeps saturating bubble and
//   flush event counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 IF/ID slot holds a real instruction
//   IF_ID_rs/rt, id_uses_*   ID source registers and whether they are read
//   id_regres, id_* control  decoded destination and control from ID
//   id_*_data, id_imm, id_pc datapath fields from ID
//   flush                    kill the ID instruction (taken branch/jump)
//   mem_stall                freeze the whole register
//   ID_EX_*                  registered fields presented to EX
//   PCWrite, IF_IDWrite      combinational enables for PC and IF/ID
//   bubble_cnt, flush_cnt    saturating event counters
module id_ex_hazard_reg #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [4:0]    IF_ID_rs,
   input  logic [4:0]    IF_ID_rt,
   input  logic          id_uses_rs,
   input  logic          id_uses_rt,
   input  logic [4:0]    id_regres,
   input  logic          id_RegWrite,
   input  logic          id_MEMRead,
   input  logic          id_MEMWrite,
   input  logic          id_MemtoReg,
   input  logic          id_ALUsrc,
   input  logic [3:0]    id_ALUop,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [DW-1:0] id_pc,
   input  logic          flush,
   input  logic          mem_stall,
   output logic          ID_EX_valid,
   output logic [4:0]    ID_EX_rs,
   output logic [4:0]    ID_EX_rt,
   output logic [4:0]    ID_EX_regres,
   output logic          ID_EX_RegWrite,
   output logic          ID_EX_MEMRead,
   output logic          ID_EX_MEMWrite,
   output logic          ID_EX_MemtoReg,
   output logic          ID_EX_ALUsrc,
   output logic [3:0]    ID_EX_ALUop,
   output logic [DW-1:0] ID_EX_rs_data,
   output logic [DW-1:0] ID_EX_rt_data,
   output logic [DW-1:0] ID_EX_imm,
   output logic [DW-1:0] ID_EX_pc,
   output logic          PCWrite,
   output logic          IF_IDWrite,
   output logic [CW-1:0] bubble_cnt,
   output logic [CW-1:0] flush_cnt
);

   logic lu_hazard;
   logic load_ctl;
   logic advance;

   // A load in EX whose destination is read by the ID instruction.
   // A load that writes $0 never creates a dependency.
   always_comb begin
      lu_hazard = ID_EX_valid && ID_EX_MEMRead && id_valid &&
                  (ID_EX_regres != 5'd0) &&
                  ((id_uses_rs && (ID_EX_regres == IF_ID_rs)) ||
                   (id_uses_rt && (ID_EX_regres == IF_ID_rt)));
   end

   // Flush overrides a hazard: the dependent instruction is being killed
   // anyway, so the front end keeps fetching from the new target.
   assign advance    = rst || (!mem_stall && (flush || !lu_hazard));
   assign PCWrite    = advance;
   assign IF_IDWrite = advance;

   // Real control only when the ID instruction is loaded normally.
   // Every other case produces a bubble, and rs/rt are zeroed too so the
   // forwarding unit never matches on a bubble.
   assign load_ctl = id_valid && !flush && !lu_hazard;

   always_ff @(posedge clk) begin
      if (rst) begin
         ID_EX_valid    <= 1'b0;
         ID_EX_rs       <= '0;
         ID_EX_rt       <= '0;
         ID_EX_regres   <= '0;
         ID_EX_RegWrite <= 1'b0;
         ID_EX_MEMRead  <= 1'b0;
         ID_EX_MEMWrite <= 1'b0;
         ID_EX_MemtoReg <= 1'b0;
         ID_EX_ALUsrc   <= 1'b0;
         ID_EX_ALUop    <= '0;
         ID_EX_rs_data  <= '0;
         ID_EX_rt_data  <= '0;
         ID_EX_imm      <= '0;
         ID_EX_pc       <= '0;
         bubble_cnt     <= '0;
         flush_cnt      <= '0;
      end else if (!mem_stall) begin
         ID_EX_valid    <= load_ctl;
         ID_EX_rs       <= load_ctl ? IF_ID_rs    : 5'd0;
         ID_EX_rt       <= load_ctl ? IF_ID_rt    : 5'd0;
         ID_EX_regres   <= load_ctl ? id_regres   : 5'd0;
         ID_EX_RegWrite <= load_ctl && id_RegWrite;
         ID_EX_MEMRead  <= load_ctl && id_MEMRead;
         ID_EX_MEMWrite <= load_ctl && id_MEMWrite;
         ID_EX_MemtoReg <= load_ctl && id_MemtoReg;
         ID_EX_ALUsrc   <= load_ctl && id_ALUsrc;
         ID_EX_ALUop    <= load_ctl ? id_ALUop    : 4'd0;
         // Data fields are don't-care in a bubble, so they load every cycle.
         ID_EX_rs_data  <= id_rs_data;
         ID_EX_rt_data  <= id_rt_data;
         ID_EX_imm      <= id_imm;
         ID_EX_pc       <= id_pc;
         if (flush) begin
            if (flush_cnt != {CW{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
         end else if (lu_hazard) begin
            if (bubble_cnt != {CW{1'b1}}) bubble_cnt <= bubble_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg
//   Directed, table-driven bench for id_ex_hazard_reg (DW=32, CW=4).
module tb_id_ex_hazard_reg;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [4:0]    IF_ID_rs, IF_ID_rt, id_regres;
   logic          id_uses_rs, id_uses_rt;
   logic          id_RegWrite, id_MEMRead, id_MEMWrite, id_MemtoReg, id_ALUsrc;
   logic [3:0]    id_ALUop;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc;
   logic          flush, mem_stall;
   logic          ID_EX_valid;
   logic [4:0]    ID_EX_rs, ID_EX_rt, ID_EX_regres;
   logic          ID_EX_RegWrite, ID_EX_MEMRead, ID_EX_MEMWrite, ID_EX_MemtoReg, ID_EX_ALUsrc;
   logic [3:0]    ID_EX_ALUop;
   logic [DW-1:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_pc;
   logic          PCWrite, IF_IDWrite;
   logic [CW-1:0] bubble_cnt, flush_cnt;

   always #5 clk = ~clk;

   id_ex_hazard_reg #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_regres(id_regres), .id_RegWrite(id_RegWrite), .id_MEMRead(id_MEMRead),
      .id_MEMWrite(id_MEMWrite), .id_MemtoReg(id_MemtoReg), .id_ALUsrc(id_ALUsrc),
      .id_ALUop(id_ALUop), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_pc(id_pc), .flush(flush), .mem_stall(mem_stall),
      .ID_EX_valid(ID_EX_valid), .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt),
      .ID_EX_regres(ID_EX_regres), .ID_EX_RegWrite(ID_EX_RegWrite),
      .ID_EX_MEMRead(ID_EX_MEMRead), .ID_EX_MEMWrite(ID_EX_MEMWrite),
      .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_ALUsrc(ID_EX_ALUsrc),
      .ID_EX_ALUop(ID_EX_ALUop), .ID_EX_rs_data(ID_EX_rs_data),
      .ID_EX_rt_data(ID_EX_rt_data), .ID_EX_imm(ID_EX_imm), .ID_EX_pc(ID_EX_pc),
      .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic       rst, vld;
      logic [4:0] rs, rt;
      logic       urs, urt;
      logic [4:0] rd;
      logic       rw, mr, fl, ms;
      logic       e_pcw, e_vld;
      logic [4:0] e_rs, e_rd;
      logic       e_rw, e_mr;
      logic [3:0] e_b, e_f;
      int         e_di;     // index of the vector whose data EX should hold
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic r, input logic v, input int rs, input int rt, input logic urs, input logic urt,
      input int rd, input logic rw, input logic mr, input logic fl, input logic ms,
      input logic epcw, input logic evld, input int ers, input int erd,
      input logic erw, input logic emr, input int eb, input int ef, input int edi);
      vec_t t;
      t.rst = r; t.vld = v; t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt;
      t.rd = 5'(rd); t.rw = rw; t.mr = mr; t.fl = fl; t.ms = ms;
      t.e_pcw = epcw; t.e_vld = evld; t.e_rs = 5'(ers); t.e_rd = 5'(erd);
      t.e_rw = erw; t.e_mr = emr; t.e_b = 4'(eb); t.e_f = 4'(ef); t.e_di = edi;
      return t;
   endfunction

   task automatic drive(input vec_t t, input int idx);
      rst = t.rst; id_valid = t.vld; IF_ID_rs = t.rs; IF_ID_rt = t.rt;
      id_uses_rs = t.urs; id_uses_rt = t.urt; id_regres = t.rd;
      id_RegWrite = t.rw; id_MEMRead = t.mr; id_MEMWrite = 1'b0;
      id_MemtoReg = t.mr; id_ALUsrc = t.mr; id_ALUop = 4'hA;
      id_rs_data = 32'hD000_0000 + 32'(idx); id_rt_data = 32'h1;
      id_imm = 32'h2; id_pc = 32'h4;
      flush = t.fl; mem_stall = t.ms;
   endtask

   vec_t vecs[$];

   initial begin
      // rst vld rs rt urs urt rd rw mr fl ms | pcw vld ers erd erw emr b f di
      vecs.push_back(mk(0,1,1,8,1,0,8,1,1,0,0, 1,1,1,8,1,1,0,0,0));   // 0 lw $8
      vecs.push_back(mk(0,1,8,10,1,1,9,1,0,0,0, 0,0,0,0,0,0,1,0,0));  // 1 add uses $8: stall
      vecs.push_back(mk(0,1,8,10,1,1,9,1,0,0,0, 1,1,8,9,1,0,1,0,2));  // 2 add proceeds
      vecs.push_back(mk(0,1,2,0,1,0,0,1,1,0,0, 1,1,2,0,1,1,1,0,3));   // 3 lw $0
      vecs.push_back(mk(0,1,0,3,1,1,4,1,0,0,0, 1,1,0,4,1,0,1,0,4));   // 4 reads $0: no stall
      vecs.push_back(mk(0,1,1,0,1,0,8,1,1,0,0, 1,1,1,8,1,1,1,0,5));   // 5 lw $8
      vecs.push_back(mk(0,1,5,8,1,0,6,1,0,0,0, 1,1,5,6,1,0,1,0,6));   // 6 rt=8 unused: no stall
      vecs.push_back(mk(0,1,5,0,1,0,8,1,0,0,0, 1,1,5,8,1,0,1,0,7));   // 7 non-load writes $8
      vecs.push_back(mk(0,1,8,0,1,0,9,1,0,0,0, 1,1,8,9,1,0,1,0,8));   // 8 reads $8: no stall
      vecs.push_back(mk(0,1,1,0,1,0,7,1,1,0,0, 1,1,1,7,1,1,1,0,9));   // 9 lw $7
      vecs.push_back(mk(0,1,2,7,1,1,11,1,0,1,0, 1,0,0,0,0,0,1,1,0));  // 10 hazard + flush
      vecs.push_back(mk(0,0,3,4,1,1,12,1,1,0,0, 1,0,0,0,0,0,1,1,0));  // 11 invalid slot
      vecs.push_back(mk(0,1,1,0,1,0,8,1,1,0,0, 1,1,1,8,1,1,1,1,12));  // 12 lw $8
      for (int k = 0; k < 3; k++)                                     // 13-15 freeze w/ hazard
         vecs.push_back(mk(0,1,8,0,1,0,9,1,0,1,1, 0,1,1,8,1,1,1,1,12));
      vecs.push_back(mk(0,1,8,0,1,0,9,1,0,0,0, 0,0,0,0,0,0,2,1,0));   // 16 release: one bubble
      vecs.push_back(mk(0,1,8,0,1,0,9,1,0,0,0, 1,1,8,9,1,0,2,1,17));  // 17 proceeds
      vecs.push_back(mk(0,1,1,0,1,0,8,1,1,0,0, 1,1,1,8,1,1,2,1,18));  // 18 lw $8
      vecs.push_back(mk(1,1,8,0,1,0,9,1,0,0,0, 1,0,0,0,0,0,0,0,0));   // 19 reset in hazard cycle
      vecs.push_back(mk(0,1,8,0,1,0,9,1,0,0,0, 1,1,8,9,1,0,0,0,20));  // 20 empty EX: proceeds

      // Reset state
      drive(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 32'(ID_EX_valid), 0);
      chk("reset_regs", {ID_EX_rs, ID_EX_rt, ID_EX_regres, ID_EX_ALUop, ID_EX_RegWrite,
                         ID_EX_MEMRead, ID_EX_MEMWrite, ID_EX_MemtoReg, ID_EX_ALUsrc}, 0);
      chk("reset_data", ID_EX_rs_data | ID_EX_pc | ID_EX_imm | ID_EX_rt_data, 0);
      chk("reset_cnts", {bubble_cnt, flush_cnt}, 0);
      chk("reset_pcwrite", {PCWrite, IF_IDWrite}, 2'b11);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t t;
         t = vecs[i];
         drive(t, i);
         #1;
         chk($sformatf("v%0d_PCWrite", i), 32'(PCWrite), 32'(t.e_pcw));
         chk($sformatf("v%0d_IF_IDWrite", i), 32'(IF_IDWrite), 32'(t.e_pcw));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), 32'(ID_EX_valid), 32'(t.e_vld));
         chk($sformatf("v%0d_rs", i), 32'(ID_EX_rs), 32'(t.e_rs));
         chk($sformatf("v%0d_regres", i), 32'(ID_EX_regres), 32'(t.e_rd));
         chk($sformatf("v%0d_RegWrite", i), 32'(ID_EX_RegWrite), 32'(t.e_rw));
         chk($sformatf("v%0d_MEMRead", i), 32'(ID_EX_MEMRead), 32'(t.e_mr));
         chk($sformatf("v%0d_ALUop", i), 32'(ID_EX_ALUop), t.e_vld ? 32'hA : 32'h0);
         chk($sformatf("v%0d_bubble_cnt", i), 32'(bubble_cnt), 32'(t.e_b));
         chk($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(t.e_f));
         if (t.e_vld)
            chk($sformatf("v%0d_rs_data", i), ID_EX_rs_data, 32'hD000_0000 + 32'(t.e_di));
         @(negedge clk);
      end

      // Saturation: 20 back-to-back flushes with flush_cnt starting at 0.
      for (int i = 0; i < 20; i++) begin
         drive(mk(0,1,3,4,1,1,5,1,0,1,0, 0,0,0,0,0,0,0,0,0), 100 + i);
         #1;
         chk($sformatf("sat%0d_PCWrite", i), 32'(PCWrite), 1);
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d_flush_cnt", i), 32'(flush_cnt), (i + 1 > 15) ? 15 : i + 1);
         chk($sformatf("sat%0d_valid", i), 32'(ID_EX_valid), 0);
         @(negedge clk);
      end
      chk("sat_bubble_cnt", 32'(bubble_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
